zone_tracker: RTL

Parametrised, frame-synchronous colour-target tracker: accumulates per-pixel hits for NUM_CLASSES colour classes (e.g. orange, plus further targets) into NUM_ZONES vertical screen strips. At each frame end it publishes, per class, a detected flag, the winning zone and the class total over a valid/ready handshake. It sits on clk_25_vga after the per-pixel colour testers and feeds the drive FSM. It generalises the single-class, three-way direction output of the current orange classifier.

---
 rtl/zone_tracker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/zone_tracker.sv
// zone_tracker: per-frame colour-class hit counts in vertical strips,
// publishing detected flag, winning strip and class total per class.
module zone_tracker #(
  parameter int NUM_CLASSES = 2,
  parameter int NUM_ZONES   = 3,
  parameter int H_ACTIVE    = 640,
  parameter int COUNT_W     = 20,
  parameter int DETECT_MIN  = 2000,
  parameter int ZW          = $clog2(NUM_ZONES),
  parameter int TW          = COUNT_W + $clog2(NUM_ZONES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      active_area,
  input  logic                      vsync,
  input  logic [NUM_CLASSES-1:0]    class_hit,
  input  logic                      result_ready,
  output logic                      result_valid,
  output logic [NUM_CLASSES-1:0]    detected,
  output logic [NUM_CLASSES*ZW-1:0] zone_idx,
  output logic [NUM_CLASSES*TW-1:0] class_total,
  output logic                      overrun
);

  localparam int ZONE_W = H_ACTIVE / NUM_ZONES;
  localparam int CW  = ($clog2(ZONE_W) > 0) ? $clog2(ZONE_W) : 1;
  localparam int KW  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int TW1 = TW + 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(ZONE_W - 1);
  localparam logic [ZW-1:0] ZONE_LAST = ZW'(NUM_ZONES - 1);
  localparam logic [KW-1:0] CLS_LAST  = KW'(NUM_CLASSES - 1);
  localparam logic [TW:0]   DMIN      = TW1'(DETECT_MIN);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACCUM, COMPARE, PUBLISH} state_t;

  state_t state, state_n;
  logic snap, frame_end, last_pair, vsync_q;
  logic [CW-1:0] zone_col;
  logic [ZW-1:0] zone, zn;
  logic [KW-1:0] cls;
  logic [COUNT_W-1:0] sv;
  logic [COUNT_W-1:0] live   [NUM_CLASSES][NUM_ZONES];
  logic [COUNT_W-1:0] live_n [NUM_CLASSES][NUM_ZONES];
  logic [COUNT_W-1:0] shadow [NUM_CLASSES][NUM_ZONES];
  logic [TW-1:0]      run_total [NUM_CLASSES];
  logic [COUNT_W-1:0] run_best  [NUM_CLASSES];
  logic [ZW-1:0]      run_idx   [NUM_CLASSES];

  assign frame_end = vsync_q & ~vsync;
  assign last_pair = (cls == CLS_LAST) && (zn == ZONE_LAST);
  assign sv        = shadow[cls][zn];

  // vsync edge detector and column-to-strip mapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      zone_col <= '0;
      zone     <= '0;
    end else begin
      vsync_q <= vsync;
      if (!active_area) begin
        zone_col <= '0;
        zone     <= '0;
      end else if (zone_col == COL_LAST) begin
        zone_col <= '0;
        if (zone != ZONE_LAST) zone <= zone + 1'b1;
      end else begin
        zone_col <= zone_col + 1'b1;
      end
    end
  end

  // next state; snapshot only when a frame ends while idle
  always_comb begin
    state_n = state;
    snap    = 1'b0;
    unique case (state)
      ACCUM: if (frame_end) begin
        snap    = 1'b1;
        state_n = COMPARE;
      end
      COMPARE: if (last_pair) state_n = PUBLISH;
      PUBLISH: state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  // next live counts: coincident pixel lands in the fresh frame
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        live_n[c][z] = snap ? '0 : live[c][z];
        if (active_area && class_hit[c] && zone == ZW'(z) &&
            live_n[c][z] != CNT_MAX)
          live_n[c][z] = live_n[c][z] + 1'b1;
      end
    end
  end

  // live and shadow counter banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int z = 0; z < NUM_ZONES; z++) begin
          live[c][z]   <= '0;
          shadow[c][z] <= '0;
        end
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int z = 0; z < NUM_ZONES; z++) begin
          live[c][z] <= live_n[c][z];
          if (snap) shadow[c][z] <= live[c][z];
        end
    end
  end

  // serial scan: one (class, zone) pair per cycle, ties keep lowest zone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls <= '0;
      zn  <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        run_total[c] <= '0;
        run_best[c]  <= '0;
        run_idx[c]   <= '0;
      end
    end else if (snap) begin
      cls <= '0;
      zn  <= '0;
    end else if (state == COMPARE) begin
      if (zn == ZONE_LAST) begin
        zn  <= '0;
        cls <= cls + 1'b1;
      end else begin
        zn <= zn + 1'b1;
      end
      if (zn == '0) begin
        run_total[cls] <= TW'(sv);
        run_best[cls]  <= sv;
        run_idx[cls]   <= '0;
      end else begin
        run_total[cls] <= run_total[cls] + TW'(sv);
        if (sv > run_best[cls]) begin
          run_best[cls] <= sv;
          run_idx[cls]  <= zn;
        end
      end
    end
  end

  // result registers, handshake and sticky loss flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      detected     <= '0;
      zone_idx     <= '0;
      class_total  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (state == PUBLISH) begin
        result_valid <= 1'b1;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          class_total[c*TW +: TW] <= run_total[c];
          zone_idx[c*ZW +: ZW]    <= run_idx[c];
          detected[c] <= ({1'b0, run_total[c]} >= DMIN);
        end
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if ((frame_end && state != ACCUM) ||
          (state == PUBLISH && result_valid && !result_ready))
        overrun <= 1'b1;
    end
  end

endmodule
